// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vend_pkg
// Brief    : Shared types and constants for the vending dispense controller:
//            controller state encoding, request-queue entry layout, drink codes.
// Revision : 1.0  initial release
// ============================================================================
package vend_pkg;

  // Controller states; CONFIRM and FAULT are only reachable in the
  // drop-confirm build but keep their encodings in every build.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRINK   = 3'd1,
    ST_CONFIRM = 3'd2,
    ST_CHANGE  = 3'd3,
    ST_FAULT   = 3'd4
  } vend_state_e;

  // Drink codes as produced by the sale FSM (code 3 is folded to NONE).
  localparam logic [1:0] DRK_NONE = 2'd0;
  localparam logic [1:0] DRK_5    = 2'd1;
  localparam logic [1:0] DRK_10   = 2'd2;

  // One queued dispense request.
  typedef struct packed {
    logic [1:0] drink;
    logic       change;
  } vend_entry_t;

  localparam int unsigned ENTRY_W = $bits(vend_entry_t);

  // Largest of three timer loads; sizes the shared down-counter.
  function automatic int unsigned vend_max3(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vend_req_fifo
// Brief    : Small synchronous request FIFO. A push while full is accepted
//            only when a pop happens in the same cycle. Also exposes the
//            next-cycle fill level so the owner can register status flags.
// Revision : 1.0  initial release
// ============================================================================
module vend_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_d_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             do_pop;
  logic             do_push;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == FULL_CNT);
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  assign rdata_o   = mem_q[rd_ptr_q];
  assign count_d   = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  assign count_d_o = count_d;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy bookkeeping; power-of-2 depth lets pointers wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vend_dispense_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vend_dispense_ctrl
// Brief    : Queues sale-FSM dispense results and serialises them into timed
//            drive pulses for the 5$ motor, 10$ motor and change ejector.
//            Define VEND_DROP_CONFIRM_EN to add drop confirmation via
//            drop_sense with a timeout into a FAULT state.
// Revision : 1.0  initial release
// ============================================================================
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned MOTOR_CYCLES   = 8,
  parameter int unsigned CHANGE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] drinks_out,
  input  logic       change_out,
  input  logic       drop_sense,
  input  logic       fault_clr,
  output logic       motor_5,
  output logic       motor_10,
  output logic       coin_ret,
  output logic       busy,
  output logic       fault,
  output logic       overflow
);

  localparam int unsigned CNT_MAX = vend_max3(MOTOR_CYCLES, CHANGE_CYCLES, TIMEOUT_CYCLES);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_MOTOR  = CW'(MOTOR_CYCLES);
  localparam logic [CW-1:0] CNT_CHANGE = CW'(CHANGE_CYCLES);
`ifdef VEND_DROP_CONFIRM_EN
  localparam logic [CW-1:0] CNT_TIMEOUT = CW'(TIMEOUT_CYCLES);
`else
  // drop_sense has no role when drops are not confirmed.
  logic unused_drop_sense;
  assign unused_drop_sense = drop_sense;
`endif

  vend_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  vend_entry_t   cur_q, cur_d;
  vend_entry_t   req_entry;
  vend_entry_t   head;
  logic          req_valid;
  logic          pop;
  logic [ENTRY_W-1:0]    fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count_d;

  logic motor_5_q,  motor_5_d;
  logic motor_10_q, motor_10_d;
  logic coin_ret_q, coin_ret_d;
  logic busy_q,     busy_d;
  logic fault_q,    fault_d;
  logic overflow_q, overflow_d;

  // Fold the sale-FSM result into a queue entry; code 3 means no drink.
  always_comb begin
    req_entry        = '0;
    req_entry.drink  = (drinks_out == DRK_5 || drinks_out == DRK_10) ? drinks_out : DRK_NONE;
    req_entry.change = change_out;
    req_valid        = (req_entry.drink != DRK_NONE) || change_out;
  end

  vend_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (req_valid),
    .wdata_i   (req_entry),
    .pop_i     (pop),
    .rdata_o   (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_d_o (fifo_count_d)
  );

  assign head = vend_entry_t'(fifo_rdata);

  // State, shared timer and in-flight entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
    end
  end

  // Next-state logic; the timer reloads on every state change and otherwise
  // counts down, holding at zero. Each timed state exits when it reads 1.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cur_d   = head;
          state_d = (head.drink != DRK_NONE) ? ST_DRINK : ST_CHANGE;
        end
      end
      ST_DRINK: begin
        if (cnt_q == CNT_ONE) begin
`ifdef VEND_DROP_CONFIRM_EN
          state_d = ST_CONFIRM;
`else
          state_d = cur_q.change ? ST_CHANGE : ST_IDLE;
`endif
        end
      end
`ifdef VEND_DROP_CONFIRM_EN
      ST_CONFIRM: begin
        if (drop_sense) begin
          state_d = cur_q.change ? ST_CHANGE : ST_IDLE;
        end else if (cnt_q == CNT_ONE) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        // Leaving FAULT abandons whatever change the entry still owed.
        if (fault_clr) state_d = ST_IDLE;
      end
`endif
      ST_CHANGE: begin
        if (cnt_q == CNT_ONE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      case (state_d)
        ST_DRINK:   cnt_d = CNT_MOTOR;
        ST_CHANGE:  cnt_d = CNT_CHANGE;
`ifdef VEND_DROP_CONFIRM_EN
        ST_CONFIRM: cnt_d = CNT_TIMEOUT;
`endif
        default:    cnt_d = '0;
      endcase
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Output decode from the upcoming state so the drives register cleanly.
  always_comb begin
    motor_5_d  = (state_d == ST_DRINK) && (cur_d.drink == DRK_5);
    motor_10_d = (state_d == ST_DRINK) && (cur_d.drink == DRK_10);
    coin_ret_d = (state_d == ST_CHANGE);
`ifdef VEND_DROP_CONFIRM_EN
    fault_d    = (state_d == ST_FAULT);
`else
    fault_d    = 1'b0;
`endif
    busy_d     = (state_d != ST_IDLE) || (fifo_count_d != '0);
    // A set in the same cycle as a clear wins so a drop is never missed.
    overflow_d = (overflow_q && !fault_clr) || (req_valid && fifo_full && !pop);
  end

  // Registered outputs; reset drops every drive asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      motor_5_q  <= 1'b0;
      motor_10_q <= 1'b0;
      coin_ret_q <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      motor_5_q  <= motor_5_d;
      motor_10_q <= motor_10_d;
      coin_ret_q <= coin_ret_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
      overflow_q <= overflow_d;
    end
  end

  assign motor_5  = motor_5_q;
  assign motor_10 = motor_10_q;
  assign coin_ret = coin_ret_q;
  assign busy     = busy_q;
  assign fault    = fault_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_vend_dispense_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_dispense_ctrl
// Brief    : Scoreboard bench for vend_dispense_ctrl. A transaction-level
//            model schedules each queued request as pulses with start edge
//            and length; a monitor measures the DUT pulses and status flags.
//            Follows VEND_DROP_CONFIRM_EN the same way the design does.
// Revision : 1.0  initial release
// ============================================================================
module tb_vend_dispense_ctrl;

  localparam int DEPTH = 4;
  localparam int M     = 8;
  localparam int C     = 4;
  localparam int T     = 64;
  localparam int BIG   = 32'h3fff_ffff;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] drinks_out = 2'd0;
  logic       change_out = 1'b0;
  logic       drop_sense = 1'b0;
  logic       fault_clr = 1'b0;
  logic       motor_5, motor_10, coin_ret, busy, fault, overflow;

  always #5 clk = ~clk;

  vend_dispense_ctrl #(
    .DEPTH          (DEPTH),
    .MOTOR_CYCLES   (M),
    .CHANGE_CYCLES  (C),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .drinks_out (drinks_out),
    .change_out (change_out),
    .drop_sense (drop_sense),
    .fault_clr  (fault_clr),
    .motor_5    (motor_5),
    .motor_10   (motor_10),
    .coin_ret   (coin_ret),
    .busy       (busy),
    .fault      (fault),
    .overflow   (overflow)
  );

  int tests = 0;
  int fails = 0;
  int pe_cnt = 0;
  always @(posedge clk) pe_cnt <= pe_cnt + 1;

  typedef struct { int drink; bit change; } ent_t;
  typedef struct { int sig; int start; int len; } pulse_t;   // 0 m5, 1 m10, 2 coin
  typedef struct { int n; bit busy; bit fault; bit ovf; } stat_t;

  ent_t   mq[$];
  pulse_t pq[$];
  stat_t  sq[$];
  int  idle_at  = -1;     // edge after which the controller is IDLE again
  bit  faulted  = 0;
  int  fault_at = 0;
  bit  m_ovf    = 0;
  int  conf_lo  = 1, conf_hi = 0, ds_edge = -1;
  int  ds_delay = 0;      // <0: never confirm; k: confirm on (k+1)-th wait edge
  bit  mon_en   = 0;
  int  npulse[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string msg);
    tests++;
    fails++;
    $display("FAIL %s", msg);
  endtask

  function automatic void model_reset();
    mq.delete(); pq.delete(); sq.delete();
    idle_at = -1; faulted = 0; fault_at = 0; m_ovf = 0;
    conf_lo = 1; conf_hi = 0; ds_edge = -1;
  endfunction

  // Effect of clock edge n on the request-level model.
  function automatic void model_step(int n, bit push, int drk, bit chg, bit fclr);
    ent_t e;
    int   x;
    bit   drop;
    drop = 0;
    if (faulted && n > fault_at && fclr) begin
      faulted = 0;
      idle_at = n;
    end
    if (n > idle_at && mq.size() > 0) begin
      e = mq.pop_front();
      x = n;
      if (e.drink != 0) begin
        pq.push_back('{(e.drink == 1) ? 0 : 1, n, M});
        x = n + M;
`ifdef VEND_DROP_CONFIRM_EN
        conf_lo = x + 1;
        if (ds_delay < 0) begin
          conf_hi = x + T; ds_edge = -1;
          faulted = 1; fault_at = x + T; idle_at = BIG;
        end else begin
          conf_hi = x + 1 + ds_delay; ds_edge = conf_hi; x = conf_hi;
        end
`endif
      end
      if (!faulted) begin
        if (e.change) begin
          pq.push_back('{2, x, C});
          idle_at = x + C;
        end else begin
          idle_at = x;
        end
      end
    end
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back('{drk, chg});
      else drop = 1;
    end
    m_ovf = (m_ovf && !fclr) || drop;
    sq.push_back('{n, (n < idle_at) || (mq.size() > 0), faulted && (n >= fault_at), m_ovf});
  endfunction

  // Sensor level for edge n: exact pulse inside a wait window, noise elsewhere.
  function automatic bit ds_for(int n);
    if (n >= conf_lo && n <= conf_hi) return (n == ds_edge);
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one cycle's inputs, advance the model, and move past the edge.
  task automatic cycle(input int drk, input bit chg, input bit fclr);
    int n;
    n = pe_cnt + 1;
    drinks_out = 2'(drk);
    change_out = chg;
    fault_clr  = fclr;
    drop_sense = ds_for(n);
    model_step(n, (drk == 1 || drk == 2 || chg), (drk == 3) ? 0 : drk, chg, fclr);
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input int maxc);
    int k;
    k = 0;
    while (!(pe_cnt + 1 > idle_at + 1 && mq.size() == 0 && !faulted)) begin
      if (k >= maxc) begin
        fail_now($sformatf("drain_timeout: still busy after %0d cycles", maxc));
        return;
      end
      cycle(0, 0, faulted && (pe_cnt + 1 > fault_at));
      k++;
    end
    repeat (2) cycle(0, 0, 0);
  endtask

  // Monitor: measures pulses and compares them and status flags in order.
  logic [2:0] mon_cur;
  bit         pv[3];
  int         ps[3];
  pulse_t     mon_p;
  stat_t      mon_s;
  always @(negedge clk) begin
    if (!mon_en) begin
      for (int i = 0; i < 3; i++) pv[i] = 0;
    end else begin
      mon_cur = {coin_ret, motor_10, motor_5};
      check("drive_exclusive", 32'($countones(mon_cur) <= 1), 1);
      for (int i = 0; i < 3; i++) begin
        if (mon_cur[i] && !pv[i]) ps[i] = pe_cnt;
        if (!mon_cur[i] && pv[i]) begin
          npulse[i]++;
          if (pq.size() == 0) begin
            fail_now($sformatf("pulse_unexpected: sig %0d start %0d len %0d", i, ps[i], pe_cnt - ps[i]));
          end else begin
            mon_p = pq.pop_front();
            check("pulse_sig", i, mon_p.sig);
            check("pulse_start", ps[i], mon_p.start);
            check("pulse_len", pe_cnt - ps[i], mon_p.len);
          end
        end
        pv[i] = mon_cur[i];
      end
      if (sq.size() > 0 && sq[0].n < pe_cnt) begin
        fail_now($sformatf("status_stale: edge %0d at %0d", sq[0].n, pe_cnt));
        void'(sq.pop_front());
      end
      if (sq.size() > 0 && sq[0].n == pe_cnt) begin
        mon_s = sq.pop_front();
        check($sformatf("busy@%0d", pe_cnt), busy, mon_s.busy);
        check($sformatf("fault@%0d", pe_cnt), fault, mon_s.fault);
        check($sformatf("overflow@%0d", pe_cnt), overflow, mon_s.ovf);
      end
    end
  end

  task automatic random_phase(input int ncyc);
    int r, drk, fcl;
    bit chg;
    for (int i = 0; i < ncyc; i++) begin
      r   = $urandom_range(0, 9);
      drk = (r < 3) ? $urandom_range(1, 3) : 0;
      chg = ($urandom_range(0, 5) == 0);
      ds_delay = ($urandom_range(0, 19) == 0) ? -1 : $urandom_range(0, 4);
      if (faulted && pe_cnt + 1 > fault_at) fcl = ($urandom_range(0, 3) == 0);
      else fcl = ($urandom_range(0, 29) == 0);
      cycle(drk, chg, fcl[0]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int i = 0; i < 3; i++) npulse[i] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check("rst_motor_5", motor_5, 0);
    check("rst_motor_10", motor_10, 0);
    check("rst_coin_ret", coin_ret, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_overflow", overflow, 0);
    rst_n  = 1'b1;
    mon_en = 1;
    repeat (2) cycle(0, 0, 0);

    // Single 5$ drink, confirmed on the fourth wait cycle.
    ds_delay = 3;
    cycle(1, 0, 0);
    drain(200);

    // Drink with change.
    ds_delay = 0;
    cycle(1, 1, 0);
    drain(200);

    // Six back-to-back 10$ requests: one dropped.
    base = npulse[1];
    repeat (6) cycle(2, 0, 0);
    check("overflow_set", overflow, 1);
    drain(500);
    check("m10_runs", npulse[1] - base, 5);
    cycle(0, 0, 1);           // clears overflow outside FAULT
    cycle(0, 0, 0);

    // Change only.
    base = npulse[0] + npulse[1];
    cycle(0, 1, 0);
    drain(100);
    check("no_motor_for_change", npulse[0] + npulse[1] - base, 0);

    // Code 3 with change returns a coin only.
    cycle(3, 1, 0);
    drain(100);

`ifdef VEND_DROP_CONFIRM_EN
    // Sensor never fires: timeout into FAULT with one entry held.
    ds_delay = -1;
    cycle(2, 1, 0);
    cycle(2, 0, 0);
    ds_delay = 0;
    for (int k = 0; k < 300 && !(faulted && pe_cnt + 1 > fault_at + 5); k++) cycle(0, 0, 0);
    if (!(faulted && pe_cnt + 1 > fault_at + 5)) fail_now("fault_wait_timeout");
    check("fault_held", fault, 1);
    check("busy_in_fault", busy, 1);
    cycle(0, 0, 1);
    drain(200);
`endif

    random_phase(600);
    ds_delay = 0;
    drain(1500);

    // Reset on the third motor_10 cycle with two entries queued.
    cycle(2, 0, 0);
    cycle(2, 0, 0);
    cycle(2, 0, 0);
    cycle(0, 0, 0);
    check("pre_reset_motor_10", motor_10, 1);
    mon_en = 0;
    rst_n  = 1'b0;
    #1;
    check("async_motor_5", motor_5, 0);
    check("async_motor_10", motor_10, 0);
    check("async_coin_ret", coin_ret, 0);
    check("async_busy", busy, 0);
    check("async_fault", fault, 0);
    check("async_overflow", overflow, 0);
    model_reset();
    drinks_out = 2'd0; change_out = 1'b0; fault_clr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n  = 1'b1;
    mon_en = 1;
    repeat (12) cycle(0, 0, 0);
    check("post_reset_busy", busy, 0);
    cycle(0, 1, 0);
    drain(100);

    check("pulses_outstanding", pq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vend_dispense_ctrl.md
# vend_dispense_ctrl

Dispense actuator controller that sits directly downstream of the vending sale FSM. It captures the one-cycle `drinks_out`/`change_out` results into a small request queue and serialises them into timed drive pulses for the 5$ motor, the 10$ motor and the change ejector. Optionally, it confirms each drink drop with a sensor and enters a fault state on timeout.

## Interface
- `DEPTH`, 4: request queue entries; power of 2, ≥2.
- `MOTOR_CYCLES`, 8: drink motor on-time in clk cycles; ≥1.
- `CHANGE_CYCLES`, 4: change ejector on-time; ≥1.
- `TIMEOUT_CYCLES`, 64: maximum wait for `drop_sense` in CONFIRM; ≥1.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `drinks_out` in 2: from sale FSM; 0 none, 1 5$ drink, 2 10$ drink, 3 treated as none.
- `change_out` in 1: from sale FSM; 1 = return one 5$ coin.
- `drop_sense` in 1: level, drink-fell sensor.
- `fault_clr` in 1: pulse; clears `fault` and `overflow`.
- `motor_5` out 1: drive 5$ drink motor.
- `motor_10` out 1: drive 10$ drink motor.
- `coin_ret` out 1: drive change ejector.
- `busy` out 1: state≠IDLE or queue non-empty.
- `fault` out 1: in FAULT state.
- `overflow` out 1: sticky; a request was dropped.

## Operation
- Push when `drinks_out`∈{1,2} or `change_out`=1. Entry = {drink[1:0], change}; drink code 3 is stored as 0. A cycle with nothing to dispense pushes nothing.
- States: IDLE, DRINK, CONFIRM, CHANGE, FAULT.
- IDLE, queue non-empty: pop.
  - drink≠0 → DRINK.
  - drink=0 → CHANGE.
- DRINK: the motor for the entry's drink code is on for `MOTOR_CYCLES` cycles. Then go to CONFIRM; without the macro, go to CHANGE if change=1, else IDLE.
- CONFIRM: all outputs off.
  - `drop_sense`=1 sampled → CHANGE if change=1, else IDLE.
  - `TIMEOUT_CYCLES` cycles without it → FAULT.
  - `drop_sense` is ignored outside CONFIRM.
- CHANGE: `coin_ret` on for `CHANGE_CYCLES` cycles, then IDLE.
- FAULT: all drives off, the queue holds, pushes continue. `fault_clr` → IDLE; the in-flight entry's remaining change is discarded.
- Queue full and push without pop: the entry is dropped and `overflow` is set. Push and pop in the same cycle when full: the push is accepted.
- One down-counter, width `$clog2(max(MOTOR_CYCLES,CHANGE_CYCLES,TIMEOUT_CYCLES)+1)`. It is loaded on every state entry.
- The counter does not wrap. The exit condition is count reaching 1.

## Timing
- All outputs are registered.
- Reset value: every output is 0, the queue is empty, and the state is IDLE.
- Request sampled at edge E while IDLE and the queue is empty: popped at edge E+1. The motor goes high after E+1 for exactly `MOTOR_CYCLES` cycles.
- At least one IDLE cycle separates consecutive entries. This gives a guaranteed off gap between actuator pulses.
- `motor_5`, `motor_10` and `coin_ret` are mutually exclusive in every cycle.
- `rst_n` low mid-operation: all drives drop asynchronously, and queued requests are lost.
- `fault_clr` while not in FAULT: clears `overflow` only.

## Configuration
- `VEND_DROP_CONFIRM_EN` defined: the CONFIRM state, the timeout and the FAULT state are present, and `drop_sense` is used.
- `VEND_DROP_CONFIRM_EN` undefined: DRINK goes directly to CHANGE or IDLE. `fault` is tied to 0, `drop_sense` is unused, and `fault_clr` only clears `overflow`.

## Structure
- Package `vend_pkg` holds:
  - the state enum;
  - the entry struct typedef;
  - drink code constants `DRK_NONE`=0, `DRK_5`=1, `DRK_10`=2.
- Sub-module `vend_req_fifo`: synchronous FIFO with parameters `DEPTH` and `WIDTH`. It provides push, pop, full, empty and the same-cycle push/pop rule above.

## Test plan
All scenarios use default parameters with the macro defined, unless stated.
- Single pulse `drinks_out`=1 at E, `drop_sense` after 3 CONFIRM cycles → `motor_5` high for exactly 8 cycles starting after E+1; `busy` is 0 after the return to IDLE.
- `drinks_out`=1 and `change_out`=1 together → 8 cycles of `motor_5`, then confirm, then 4 cycles of `coin_ret`. There is no overlap.
- `drinks_out`=2 for 6 consecutive cycles → 1 in flight, 4 queued, 1 dropped. `overflow`=1 and exactly 5 `motor_10` runs occur.
- `drop_sense` held at 0 → `fault`=1 64 cycles after `motor_10` falls, and the queued entry is held. `fault_clr` → IDLE, then the next entry dispenses.
- `change_out` only, with `drinks_out`=0 → `coin_ret` high for 4 cycles and no motor pulse.
- `rst_n` low at the 3rd `motor_10` cycle with 2 entries queued → all outputs 0 immediately, then queue empty and `busy`=0 after release.
